// File: rtl/hub75_bcm_scan_if.sv
// Pixel-RAM read port and HUB75 panel pins of the BCM scan controller.
// master = scan controller; slave = RAM and panel side.
interface hub75_bcm_scan_if #(
  parameter int COL_BITS = 6,
  parameter int ROW_BITS = 5,
  parameter int BPC      = 5
);
  logic [ROW_BITS+COL_BITS-1:0] ram_addr;
  logic                         ram_rd;
  logic [6*BPC-1:0]             ram_rdata;
  logic                         hub_r1;
  logic                         hub_g1;
  logic                         hub_b1;
  logic                         hub_r2;
  logic                         hub_g2;
  logic                         hub_b2;
  logic                         hub_ck;
  logic                         hub_st;
  logic                         hub_oe;
  logic [ROW_BITS-1:0]          lines;
  logic                         frame_start;

  modport master (
    output ram_addr, ram_rd,
    input  ram_rdata,
    output hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2,
    output hub_ck, hub_st, hub_oe, lines, frame_start
  );

  modport slave (
    input  ram_addr, ram_rd,
    output ram_rdata,
    input  hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2,
    input  hub_ck, hub_st, hub_oe, lines, frame_start
  );
endinterface

// File: rtl/hub75_bcm_scan.sv
// HUB75 scan controller with binary-coded modulation; the next bitplane is
// shifted out while the previously latched one is on display.
module hub75_bcm_scan #(
  parameter int COL_BITS = 6,
  parameter int ROW_BITS = 5,
  parameter int BPC      = 5,
  parameter int BASE_OE  = 8,
  parameter int DEAD     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  hub75_bcm_scan_if.master bus
);
  localparam int PW = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int TW = $clog2((BASE_OE << (BPC - 1)) + 1);
  localparam int SW = (DEAD > 2) ? $clog2(DEAD) : 1;
  localparam logic [COL_BITS-1:0] COL_LAST   = '1;
  localparam logic [PW-1:0]       PLANE_LAST = PW'(BPC - 1);
  localparam logic [SW-1:0]       DEAD_LAST  = SW'(DEAD - 1);

  // S_IDLE only exists for the single cycle following reset.
  typedef enum logic [2:0] {
    S_IDLE, S_PREFETCH, S_SHIFT, S_WAIT, S_BLANK, S_LATCH
  } state_t;

  state_t                       state_reg, state_next;
  logic [SW-1:0]                sub_reg, sub_next;
  logic [COL_BITS-1:0]          col_reg, col_next, col_inc;
  logic [ROW_BITS-1:0]          row_reg, row_next;
  logic [PW-1:0]                plane_reg, plane_next;
  logic [TW-1:0]                timer_reg, timer_next;
  logic                         oe_on_reg, oe_on_next;
  logic                         ck_reg, ck_next;
  logic                         st_reg, st_next;
  logic                         fs_reg, fs_next;
  logic                         rd_reg, rd_next;
  logic [ROW_BITS+COL_BITS-1:0] addr_reg, addr_next;
  logic [ROW_BITS-1:0]          lines_reg, lines_next;
  logic [5:0]                   rgb_reg, rgb_next;
  logic [5:0]                   plane_bits;

  // Channel gi of the RAM word: 0=B1 1=G1 2=R1 3=B2 4=G2 5=R2.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_chan
      logic [BPC-1:0] chan;
      assign chan           = bus.ram_rdata[gi*BPC +: BPC];
      assign plane_bits[gi] = chan[plane_reg];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    sub_next   = sub_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    plane_next = plane_reg;
    timer_next = (timer_reg != '0) ? timer_reg - 1'b1 : timer_reg;
    case (state_reg)
      S_IDLE: begin
        state_next = S_PREFETCH;
        sub_next   = '0;
      end
      S_PREFETCH: begin
        if (sub_reg == '0) begin
          sub_next = SW'(1);
        end else begin
          state_next = S_SHIFT;
          sub_next   = '0;
          col_next   = '0;
        end
      end
      S_SHIFT: begin
        if (sub_reg == '0) begin
          sub_next = SW'(1);
        end else begin
          sub_next = '0;
          if (col_reg == COL_LAST)
            state_next = (timer_next != '0) ? S_WAIT : S_BLANK;
          else
            col_next = col_reg + 1'b1;
        end
      end
      S_WAIT: begin
        if (timer_next == '0)
          state_next = S_BLANK;
      end
      S_BLANK: begin
        if (sub_reg == DEAD_LAST) begin
          state_next = S_LATCH;
          sub_next   = '0;
        end else begin
          sub_next = sub_reg + 1'b1;
        end
      end
      S_LATCH: begin
        state_next = S_PREFETCH;
        sub_next   = '0;
        timer_next = TW'(BASE_OE << plane_reg);
        if (plane_reg == PLANE_LAST) begin
          plane_next = '0;
          row_next   = row_reg + 1'b1;
        end else begin
          plane_next = plane_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Output registers are loaded with the values belonging to the next cycle.
    col_inc    = col_next + 1'b1;
    oe_on_next = (timer_next != '0);
    ck_next    = 1'b0;
    st_next    = 1'b0;
    fs_next    = 1'b0;
    rd_next    = 1'b0;
    addr_next  = addr_reg;
    lines_next = lines_reg;
    rgb_next   = rgb_reg;
    case (state_next)
      S_PREFETCH: begin
        if (sub_next == '0) begin
          rd_next   = 1'b1;
          addr_next = {row_next, {COL_BITS{1'b0}}};
        end
      end
      S_SHIFT: begin
        if (sub_next == '0) begin
          rgb_next = plane_bits;
          if (col_next != COL_LAST) begin
            rd_next   = 1'b1;
            addr_next = {row_reg, col_inc};
          end
        end else begin
          ck_next = 1'b1;
        end
      end
      S_BLANK: begin
        if (state_reg != S_BLANK)
          lines_next = row_reg;
      end
      S_LATCH: begin
        st_next = 1'b1;
        fs_next = (row_reg == '0) && (plane_reg == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      sub_reg   <= '0;
      col_reg   <= '0;
      row_reg   <= '0;
      plane_reg <= '0;
      timer_reg <= '0;
      oe_on_reg <= 1'b0;
      ck_reg    <= 1'b0;
      st_reg    <= 1'b0;
      fs_reg    <= 1'b0;
      rd_reg    <= 1'b0;
      addr_reg  <= '0;
      lines_reg <= '0;
      rgb_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sub_reg   <= sub_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
      plane_reg <= plane_next;
      timer_reg <= timer_next;
      oe_on_reg <= oe_on_next;
      ck_reg    <= ck_next;
      st_reg    <= st_next;
      fs_reg    <= fs_next;
      rd_reg    <= rd_next;
      addr_reg  <= addr_next;
      lines_reg <= lines_next;
      rgb_reg   <= rgb_next;
    end
  end

  // Enable gates OE combinationally so dropping it blanks without delay.
  assign bus.hub_oe      = ~(enable & oe_on_reg);
  assign bus.hub_ck      = ck_reg;
  assign bus.hub_st      = st_reg;
  assign bus.frame_start = fs_reg;
  assign bus.ram_rd      = rd_reg;
  assign bus.ram_addr    = addr_reg;
  assign bus.lines       = lines_reg;
  assign bus.hub_b1      = rgb_reg[0];
  assign bus.hub_g1      = rgb_reg[1];
  assign bus.hub_r1      = rgb_reg[2];
  assign bus.hub_b2      = rgb_reg[3];
  assign bus.hub_g2      = rgb_reg[4];
  assign bus.hub_r2      = rgb_reg[5];
endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Scoreboard bench for hub75_bcm_scan on a 4x4 panel with 3 bitplanes:
// planes 0/1 are shift-bound, plane 2 is display-bound.
module tb_hub75_bcm_scan;
  localparam int CB   = 2;
  localparam int RB   = 2;
  localparam int NP   = 3;
  localparam int BOE  = 4;
  localparam int DD   = 2;
  localparam int COLS = 4;
  localparam int ROWS = 4;

  // Hand-computed per displayed plane: OE-low length and latch period
  // (shift takes 2+2*4=10 cycles, plus DEAD+1=3).
  int oe_tab[NP]  = '{4, 8, 16};
  int per_tab[NP] = '{13, 13, 19};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  always #5 clk = ~clk;

  hub75_bcm_scan_if #(.COL_BITS(CB), .ROW_BITS(RB), .BPC(NP)) bus ();

  hub75_bcm_scan #(
    .COL_BITS(CB), .ROW_BITS(RB), .BPC(NP), .BASE_OE(BOE), .DEAD(DD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .bus(bus)
  );

  typedef struct {
    int lines;
    int fs;
    int ck;
    int oe;
    int per;
    bit chk_per;
  } lat_t;

  lat_t       lat_q[$];
  int         addr_q[$];
  logic [5:0] rgb_q[$];
  int         cmp_cnt = 0;
  int         mis_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    cmp_cnt++;
    if (act != exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Test data: channel k of address a holds (a + 3k) mod 8.
  function automatic logic [6*NP-1:0] ram_word(input int a);
    logic [6*NP-1:0] w;
    for (int k = 0; k < 6; k++) w[k*NP +: NP] = NP'(a + 3 * k);
    return w;
  endfunction

  function automatic logic [5:0] exp_rgb(input int r, input int p, input int c);
    logic [6*NP-1:0] w;
    logic [5:0]      v;
    w = ram_word(r * COLS + c);
    for (int k = 0; k < 6; k++) v[k] = w[k*NP + p];
    return v;
  endfunction

  // Registered-read RAM; junk when no read was issued the cycle before.
  always @(posedge clk)
    bus.ram_rdata <= bus.ram_rd ? ram_word(int'(bus.ram_addr)) : '1;

  // Latch n (counted from reset) latches row (n/3)%4, plane n%3.
  task automatic push_latches(input int n0, input int n1, input int en_end);
    lat_t e;
    int   r, p, pp;
    for (int n = n0; n < n1; n++) begin
      r         = (n / NP) % ROWS;
      p         = n % NP;
      pp        = (n + NP - 1) % NP;
      e.lines   = r;
      e.fs      = (n % (NP * ROWS) == 0) ? 1 : 0;
      e.ck      = COLS;
      e.oe      = (n == 0 || n >= en_end) ? 0 : oe_tab[pp];
      e.per     = per_tab[pp];
      e.chk_per = (n != 0);
      lat_q.push_back(e);
      for (int c = 0; c < COLS; c++) begin
        addr_q.push_back(r * COLS + c);
        rgb_q.push_back(exp_rgb(r, p, c));
      end
    end
  endtask

  // Monitor: pops expectations whenever the DUT issues a read, a clock or a latch.
  int         cyc_cnt, oe_cnt, ck_cnt, lat_idx;
  logic       prev_ck;
  logic [RB-1:0] prev_lines;
  always @(negedge clk) begin
    if (reset) begin
      cyc_cnt = 0; oe_cnt = 0; ck_cnt = 0; lat_idx = 0;
      prev_ck = 1'b0; prev_lines = bus.lines;
      lat_q.delete(); addr_q.delete(); rgb_q.delete();
    end else begin
      cyc_cnt++;
      if (!bus.hub_oe) oe_cnt++;
      chk("pulse_rules", {bus.hub_st & bus.hub_ck, bus.frame_start & ~bus.hub_st}, 0);
      if (bus.lines != prev_lines) chk("lines_in_blank", bus.hub_oe, 1);
      if (bus.ram_rd && addr_q.size() > 0) chk("ram_addr", bus.ram_addr, addr_q.pop_front());
      if (bus.hub_ck && !prev_ck) begin
        ck_cnt++;
        if (rgb_q.size() > 0)
          chk("rgb_bits", {bus.hub_r2, bus.hub_g2, bus.hub_b2, bus.hub_r1, bus.hub_g1, bus.hub_b1},
              rgb_q.pop_front());
      end
      if (bus.hub_st) begin
        if (lat_q.size() > 0) begin
          lat_t e;
          e = lat_q.pop_front();
          $display("latch %0d: lines=%0d fs=%0d period=%0d oe_low=%0d ck_edges=%0d",
                   lat_idx, bus.lines, bus.frame_start, cyc_cnt, oe_cnt, ck_cnt);
          chk("lines", bus.lines, e.lines);
          chk("frame_start", bus.frame_start, e.fs);
          chk("ck_edges", ck_cnt, e.ck);
          chk("oe_low", oe_cnt, e.oe);
          if (e.chk_per) chk("latch_period", cyc_cnt, e.per);
        end
        cyc_cnt = 0; oe_cnt = 0; ck_cnt = 0;
        lat_idx++;
      end
      prev_ck    = bus.hub_ck;
      prev_lines = bus.lines;
    end
  end

  task automatic check_reset_vals(input string tag);
    $display("reset check %s", tag);
    chk({tag, "_hub_ck"}, bus.hub_ck, 0);
    chk({tag, "_hub_st"}, bus.hub_st, 0);
    chk({tag, "_hub_oe"}, bus.hub_oe, 1);
    chk({tag, "_lines"}, bus.lines, 0);
    chk({tag, "_rgb"}, {bus.hub_r2, bus.hub_g2, bus.hub_b2, bus.hub_r1, bus.hub_g1, bus.hub_b1}, 0);
    chk({tag, "_ram_addr"}, bus.ram_addr, 0);
    chk({tag, "_ram_rd"}, bus.ram_rd, 0);
    chk({tag, "_frame_start"}, bus.frame_start, 0);
  endtask

  task automatic wait_latches(input int k);
    int cnt = 0;
    for (int i = 0; i < k * 40 + 100 && cnt < k; i++) begin
      @(posedge clk); #1;
      if (bus.hub_st) cnt++;
    end
    chk("latches_seen", cnt, k);
  endtask

  task automatic wait_col(input int col);
    int found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(posedge clk); #1;
      if (bus.ram_rd && int'(bus.ram_addr[CB-1:0]) == col) found = 1;
    end
    chk("col_issue_seen", found, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("init");
    @(negedge clk); #1;
    push_latches(0, 60, 24);
    reset = 1'b0;
    wait_latches(24);
    enable = 1'b0;
    wait_latches(36);
    enable = 1'b1;
    wait_col(2);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("mid");
    @(negedge clk); #1;
    push_latches(0, 4, 4);
    reset = 1'b0;
    wait_latches(4);
    @(negedge clk); #1;
    chk("lat_q_left", lat_q.size(), 0);
    chk("addr_q_left", addr_q.size(), 0);
    chk("rgb_q_left", rgb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end
endmodule

// File: doc/hub75_bcm_scan.md
Name: hub75_bcm_scan

Overview:
- Next-generation HUB75/HUB75E scan controller. Replaces the fixed 64-column, 5-bit PWM interface.
- Parametrised in panel width, scan-row count and colour depth.
- Drives intensity with binary-coded modulation (BCM): per-bitplane output-enable (OE) time is weighted by the plane's bit value.
- Overlaps shifting of the next bitplane with display of the current one. Sits between the dual-port pixel RAM (read port) and the panel connector pins.

Parameters:
- COL_BITS, 6: log2 of panel columns (COLS = 2**COL_BITS).
- ROW_BITS, 5: log2 of scan rows; also the width of `lines`.
- BPC, 5: bits per colour channel; number of bitplanes.
- BASE_OE, 8: OE-low cycles for bitplane 0. Plane p displays BASE_OE<<p cycles.
- DEAD, 2: blanking cycles before each latch (anti-ghosting); minimum 1.

Ports:
- clk, input, 1: single system clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: 1 = panel may be lit; 0 = hub_oe held 1, scanning continues.
- ram_addr, output, ROW_BITS+COL_BITS: pixel RAM read address {row, col}.
- ram_rd, output, 1: read strobe, high in each address-issue cycle.
- ram_rdata, input, 6*BPC: {R2,G2,B2,R1,G1,B1}, each BPC bits, MSB first. Valid one cycle after its address (registered RAM).
- hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2, output, 1 each: registered bit p of the matching channel.
- hub_ck, output, 1: registered shift clock; the panel samples on its rising edge.
- hub_st, output, 1: latch strobe, one-cycle high pulse.
- hub_oe, output, 1: active-low output enable; 1 = blanked.
- lines, output, ROW_BITS: row address (E,D,C,B,A for ROW_BITS=5).
- frame_start, output, 1: one-cycle pulse on the latch of row 0, plane 0.

Behaviour:
- Reset values (synchronous; also applies when reset is asserted mid-operation):
  - hub_ck=0, hub_st=0, hub_oe=1, lines=0.
  - All six rgb outputs = 0.
  - ram_addr=0, ram_rd=0, frame_start=0.
  - Shift target = row 0, plane 0; display timer expired.
  - First cycle after reset deasserts = first PREFETCH cycle.
- Scan order: for row r = 0..2**ROW_BITS-1, for plane p = 0..BPC-1. Wraps from (last row, BPC-1) to (0, 0).
- Shift FSM, states PREFETCH -> SHIFT -> WAIT -> BLANK -> LATCH -> PREFETCH:
  - PREFETCH: 2 cycles. ram_addr={r,0} and ram_rd=1 in the first cycle; ram_rd=0 in the second.
  - SHIFT: 2 cycles per column c.
    - L-cycle: hub_ck=0; rgb outputs update to bit p of the data read for column c.
    - H-cycle: hub_ck=1; rgb outputs hold.
    - Address for column c+1 is issued (ram_rd=1) in the L-cycle of column c, i.e. 2 cycles ahead of its L-cycle.
    - Exactly COLS rising edges on hub_ck per row shift.
  - WAIT: hub_ck=0. Remain until the display timer has expired; skipped when it is already expired.
  - BLANK: DEAD cycles with hub_oe=1. lines <= r in the first BLANK cycle.
  - LATCH: 1 cycle with hub_st=1 and hub_oe=1. frame_start=1 iff r=0 and p=0. The display plane becomes p, then (r,p) advances.
- Display timer:
  - Loaded with BASE_OE<<p at LATCH.
  - hub_oe = !enable for exactly that many cycles, starting the cycle after LATCH; hub_oe=1 afterwards until the next LATCH.
  - Timer width covers BASE_OE<<(BPC-1).
- Latch period: max(2+2*COLS, BASE_OE<<p) + DEAD + 1 cycles.
- Invariants:
  - lines changes only while hub_oe=1, and never in the same cycle hub_oe falls.
  - hub_st is never high while hub_ck=1.
- Enable behaviour: enable is sampled per cycle for OE only. Deasserting enable mid-display blanks immediately without altering timing.
- Arithmetic: all counters wrap modulo their width; no saturation anywhere.

Test Plan:
- Reset: hold reset 3 cycles, then mid-SHIFT at column 10 -> all outputs at reset values the cycle after reset; next ram_addr issued is {0,0}.
- Column shift (COL_BITS=2, BPC=3): RAM returns col index in every channel. Expect:
  - ram_addr sequence 0,1,2,3;
  - 4 hub_ck rising edges;
  - hub_r1 during each H-cycle = bit 0 of the column index.
- BCM weights (COL_BITS=2, BASE_OE=16, BPC=3, DEAD=2, enable=1): hub_oe low runs of 16, 32, 64 cycles for planes 0, 1, 2. Latch periods = 16+3, 32+3, 64+3.
- Shift-bound timing (defaults): plane 0 OE low 8 cycles; latch period 133 cycles; hub_oe=1 for the remaining 125.
- Row sequencing (ROW_BITS=2, BPC=2): lines steps 0,1,2,3,0, each change inside a blank window. frame_start pulses every 8 latches, coincident with hub_st.
- Enable low: hub_oe stays 1 for 3 full frames; hub_st and frame_start cadence identical to the enable=1 case.
